// File: rtl/cycle_printer.sv
// cycle_printer: scans vertmat for flagged nodes and renders each predecessor chain
// as fixed-width decimal indices joined by arrows, one frame line per chain.
module cycle_printer #(
    parameter int NODES      = 64,
    parameter int PRED_W     = 6,
    parameter int WEIGHT_W   = 24,
    parameter int DIGITS     = 2,
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int BLANK_CHAR = 10,
    parameter int ARROW_CHAR = 37,
    parameter int TRUNC_CHAR = 38,
    localparam int VW = 1 + PRED_W + WEIGHT_W,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              print_start,
    input  logic [VW-1:0]     vertmat_q_b,
    output logic [PRED_W-1:0] vertmat_addr_b,
    output logic [VW-1:0]     vertmat_data_b,
    output logic              vertmat_we_b,
    output logic [5:0]        frame_char,
    output logic [XW-1:0]     frame_x,
    output logic [YW-1:0]     frame_y,
    output logic              frame_we,
    output logic              print_busy,
    output logic              print_done,
    output logic [PRED_W:0]   cycle_count
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRED_W-1:0] J_LAST  = PRED_W'(NODES - 1);
    localparam logic [PRED_W-1:0] J_ONE   = PRED_W'(1);
    localparam logic [PRED_W:0]   HOP_ONE = (PRED_W + 1)'(1);
    localparam logic [PRED_W:0]   HOP_MAX = (PRED_W + 1)'(NODES);
    localparam logic [DW-1:0]     D_TOP   = DW'(DIGITS - 1);
    localparam logic [DW-1:0]     D_ONE   = DW'(1);
    localparam logic [XW-1:0]     X_LAST  = XW'(COLS - 1);
    localparam logic [XW-1:0]     X_ONE   = XW'(1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(ROWS - 1);
    localparam logic [YW-1:0]     Y_ONE   = YW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_CHECK, S_DIGIT, S_ARROW, S_LOAD, S_TRUNC, S_NEWLINE, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PRED_W-1:0]   r_j, r_k, r_m, r_l;
    logic [PRED_W-1:0]   w_j_nxt, w_k_nxt, w_m_nxt, w_l_nxt;
    logic [VW-1:0]       r_w, w_w_nxt;
    logic [PRED_W:0]     r_hop, w_hop_nxt, w_hop_inc;
    logic [DW-1:0]       r_d, w_d_nxt;
    logic [XW-1:0]       r_x, w_x_nxt;
    logic [YW-1:0]       r_y, w_y_nxt, w_y_inc;
    logic                r_done, w_done_nxt;
    logic [PRED_W:0]     r_count, w_count_nxt;
    logic                w_adv;
    logic [4*DIGITS-1:0] w_bcd;
    logic [PRED_W-1:0]   w_mshift;
    logic [3:0]          w_digit;
    logic                w_nz;

    // Shift-and-add-3 binary to BCD of the node being printed.
    always_comb begin
        w_bcd    = '0;
        w_mshift = r_m;
        for (int unsigned i = 0; i < PRED_W; i++) begin
            for (int unsigned g = 0; g < DIGITS; g++) begin
                if (w_bcd[4*g +: 4] >= 4'd5)
                    w_bcd[4*g +: 4] = w_bcd[4*g +: 4] + 4'd3;
            end
            w_bcd    = {w_bcd[4*DIGITS-2:0], w_mshift[PRED_W-1]};
            w_mshift = w_mshift << 1;
        end
    end

    // w_nz: some digit at or above the current position is non-zero.
    always_comb begin
        w_digit = '0;
        w_nz    = 1'b0;
        for (int unsigned g = 0; g < DIGITS; g++) begin
            if (g == int'(r_d))
                w_digit = w_bcd[4*g +: 4];
            if (g >= int'(r_d) && w_bcd[4*g +: 4] != 4'd0)
                w_nz = 1'b1;
        end
    end

    assign w_hop_inc   = r_hop + HOP_ONE;
    assign w_y_inc     = (r_y == Y_LAST) ? '0 : r_y + Y_ONE;
    assign frame_x     = r_x;
    assign frame_y     = r_y;
    assign print_busy  = (r_state != S_IDLE);
    assign print_done  = r_done;
    assign cycle_count = r_count;

    always_comb begin
        w_state_nxt    = r_state;
        w_j_nxt        = r_j;
        w_k_nxt        = r_k;
        w_m_nxt        = r_m;
        w_l_nxt        = r_l;
        w_w_nxt        = r_w;
        w_hop_nxt      = r_hop;
        w_d_nxt        = r_d;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_done_nxt     = r_done;
        w_count_nxt    = r_count;
        w_adv          = 1'b0;
        vertmat_addr_b = '0;
        vertmat_data_b = '0;
        vertmat_we_b   = 1'b0;
        frame_we       = 1'b0;
        frame_char     = '0;

        case (r_state)
            S_IDLE: begin
                if (print_start) begin
                    w_j_nxt     = '0;
                    w_done_nxt  = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                vertmat_addr_b = r_j;
                w_state_nxt    = S_CHECK;
            end
            S_CHECK: begin
                if (vertmat_q_b[VW-1]) begin
                    w_w_nxt     = vertmat_q_b;
                    w_k_nxt     = r_j;
                    w_m_nxt     = r_j;
                    w_hop_nxt   = '0;
                    w_d_nxt     = D_TOP;
                    w_state_nxt = S_DIGIT;
                end else if (r_j == J_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_j_nxt     = r_j + J_ONE;
                    w_state_nxt = S_SCAN;
                end
            end
            S_DIGIT: begin
                frame_we   = 1'b1;
                frame_char = (r_d != '0 && !w_nz) ? 6'(BLANK_CHAR) : {2'b00, w_digit};
                w_adv      = 1'b1;
                if (r_d == D_TOP) begin
                    vertmat_addr_b = r_m;
                    vertmat_data_b = {1'b0, r_w[VW-2:0]};
                    vertmat_we_b   = 1'b1;
                    w_l_nxt        = r_w[VW-2 -: PRED_W];
                end
                if (r_d == '0) begin
                    if (r_m == r_k && r_hop != '0) begin
                        w_count_nxt = r_count + HOP_ONE;
                        w_state_nxt = S_NEWLINE;
                    end else begin
                        w_state_nxt = S_ARROW;
                    end
                end else begin
                    w_d_nxt = r_d - D_ONE;
                end
            end
            S_ARROW: begin
                frame_we   = 1'b1;
                frame_char = 6'(ARROW_CHAR);
                w_adv      = 1'b1;
                w_hop_nxt  = w_hop_inc;
                if (w_hop_inc == HOP_MAX) begin
                    w_state_nxt = S_TRUNC;
                end else begin
                    vertmat_addr_b = r_l;
                    w_m_nxt        = r_l;
                    w_state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                w_w_nxt     = vertmat_q_b;
                w_d_nxt     = D_TOP;
                w_state_nxt = S_DIGIT;
            end
            S_TRUNC: begin
                frame_we    = 1'b1;
                frame_char  = 6'(TRUNC_CHAR);
                w_adv       = 1'b1;
                w_count_nxt = r_count + HOP_ONE;
                w_state_nxt = S_NEWLINE;
            end
            S_NEWLINE: begin
                w_x_nxt = '0;
                w_y_nxt = w_y_inc;
                if (r_j == J_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_j_nxt     = r_j + J_ONE;
                    w_state_nxt = S_SCAN;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_adv) begin
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_inc;
            end else begin
                w_x_nxt = r_x + X_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_m     <= '0;
            r_l     <= '0;
            r_w     <= '0;
            r_hop   <= '0;
            r_d     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_m     <= w_m_nxt;
            r_l     <= w_l_nxt;
            r_w     <= w_w_nxt;
            r_hop   <= w_hop_nxt;
            r_d     <= w_d_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule
